// File: rtl/memory_arbiter_if.sv
// -----------------------------------------------------------------------------
// reset_if
//   Reset bundle shared by the arbiter and the memory side.
//   rst_n : asynchronous, active-low reset
// -----------------------------------------------------------------------------
interface reset_if;
    logic rst_n;

    modport sink   (input  rst_n);
    modport source (output rst_n);
endinterface

// File: rtl/memory_arbiter.sv
// -----------------------------------------------------------------------------
// memory_arbiter
//   Two-to-one round-robin arbiter. It merges the instruction-cache (port 0)
//   and data-cache (port 1) memory request streams into one request toward
//   main memory, with a single outstanding transaction. The granted request
//   is latched so the memory side sees stable fields for the whole access.
//
// Ports
//   clk                       system clock, rising edge
//   rst_if                    reset bundle (rst_n: asynchronous, active-low)
//   pN_valid/op/size/addr/wdata  request from port N (op: 0 rd, 1 wr)
//   pN_fulfilled, pN_rdata    one-cycle completion pulse and read data
//   hmem_valid/op/size/addr/wdata  latched request toward memory
//   hmem_fulfilled, hmem_rdata     memory completion pulse and read data
//   stall_cnt0/1              per-port stall cycle counters
//
// Build option
//   MEM_ARB_STALL_CNT_EN : when defined, saturating stall counters are built;
//                          otherwise stall_cnt0/1 are tied to zero.
// -----------------------------------------------------------------------------
module memory_arbiter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    reset_if.sink           rst_if,
    input  logic            p0_valid,
    input  logic            p0_op,
    input  logic [1:0]      p0_size,
    input  logic [XLEN-1:0] p0_addr,
    input  logic [XLEN-1:0] p0_wdata,
    output logic            p0_fulfilled,
    output logic [XLEN-1:0] p0_rdata,
    input  logic            p1_valid,
    input  logic            p1_op,
    input  logic [1:0]      p1_size,
    input  logic [XLEN-1:0] p1_addr,
    input  logic [XLEN-1:0] p1_wdata,
    output logic            p1_fulfilled,
    output logic [XLEN-1:0] p1_rdata,
    output logic            hmem_valid,
    output logic            hmem_op,
    output logic [1:0]      hmem_size,
    output logic [XLEN-1:0] hmem_addr,
    output logic [XLEN-1:0] hmem_wdata,
    input  logic            hmem_fulfilled,
    input  logic [XLEN-1:0] hmem_rdata,
    output logic [31:0]     stall_cnt0,
    output logic [31:0]     stall_cnt1
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    logic rst_n;
    assign rst_n = rst_if.rst_n;

    state_e            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_grant_q, last_grant_d;
    logic              op_q, op_d;
    logic [1:0]        size_q, size_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [XLEN-1:0]   rdata_q, rdata_d;

    logic              grant_en;
    logic              grant_port;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        op_d         = op_q;
        size_d       = size_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        grant_en     = 1'b0;
        grant_port   = 1'b0;

        case (state_q)
            IDLE: begin
                // On a tie the port that did not win last time is served.
                if (p0_valid && p1_valid) begin
                    grant_en   = 1'b1;
                    grant_port = ~last_grant_q;
                end else if (p0_valid) begin
                    grant_en   = 1'b1;
                    grant_port = 1'b0;
                end else if (p1_valid) begin
                    grant_en   = 1'b1;
                    grant_port = 1'b1;
                end

                if (grant_en) begin
                    owner_d      = grant_port;
                    last_grant_d = grant_port;
                    op_d         = grant_port ? p1_op    : p0_op;
                    size_d       = grant_port ? p1_size  : p0_size;
                    addr_d       = grant_port ? p1_addr  : p0_addr;
                    wdata_d      = grant_port ? p1_wdata : p0_wdata;
                    state_d      = BUSY;
                end
            end
            BUSY: begin
                if (hmem_fulfilled) begin
                    rdata_d = hmem_rdata;
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            op_q         <= 1'b0;
            size_q       <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            op_q         <= op_d;
            size_q       <= size_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
        end
    end

    assign hmem_valid   = (state_q == BUSY);
    assign hmem_op      = op_q;
    assign hmem_size    = size_q;
    assign hmem_addr    = addr_q;
    assign hmem_wdata   = wdata_q;

    assign p0_fulfilled = (state_q == RESP) && !owner_q;
    assign p1_fulfilled = (state_q == RESP) &&  owner_q;
    assign p0_rdata     = rdata_q;
    assign p1_rdata     = rdata_q;

`ifdef MEM_ARB_STALL_CNT_EN
    logic [31:0] stall_cnt0_q, stall_cnt0_d;
    logic [31:0] stall_cnt1_q, stall_cnt1_d;
    logic        stall0;
    logic        stall1;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // A waiting port stalls when it loses the IDLE grant, or while the
    // other port owns the arbiter in BUSY/RESP.
    always_comb begin
        stall0       = p0_valid && ((grant_en &&  grant_port) ||
                                    (state_q != IDLE &&  owner_q));
        stall1       = p1_valid && ((grant_en && !grant_port) ||
                                    (state_q != IDLE && !owner_q));
        stall_cnt0_d = stall0 ? sat_inc(stall_cnt0_q) : stall_cnt0_q;
        stall_cnt1_d = stall1 ? sat_inc(stall_cnt1_q) : stall_cnt1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt0_q <= '0;
            stall_cnt1_q <= '0;
        end else begin
            stall_cnt0_q <= stall_cnt0_d;
            stall_cnt1_q <= stall_cnt1_d;
        end
    end

    assign stall_cnt0 = stall_cnt0_q;
    assign stall_cnt1 = stall_cnt1_q;
`else
    assign stall_cnt0 = 32'd0;
    assign stall_cnt1 = 32'd0;
`endif

endmodule

// File: tb/tb_memory_arbiter.sv
// -----------------------------------------------------------------------------
// tb_memory_arbiter
//   Self-checking bench for memory_arbiter. Requesters and a memory responder
//   are modelled at transaction level and advanced one cycle at a time; each
//   scenario task checks the logged traffic against the arbitration rules.
// -----------------------------------------------------------------------------
module tb_memory_arbiter;

    logic        clk = 1'b0;
    reset_if     rst_if_i ();

    logic        p0_valid, p0_op, p1_valid, p1_op;
    logic [1:0]  p0_size, p1_size;
    logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic        p0_fulfilled, p1_fulfilled;
    logic [31:0] p0_rdata, p1_rdata;
    logic        hmem_valid, hmem_op;
    logic [1:0]  hmem_size;
    logic [31:0] hmem_addr, hmem_wdata;
    logic        hmem_fulfilled;
    logic [31:0] hmem_rdata;
    logic [31:0] stall_cnt0, stall_cnt1;

    memory_arbiter #(.XLEN(32)) dut (
        .clk(clk), .rst_if(rst_if_i),
        .p0_valid(p0_valid), .p0_op(p0_op), .p0_size(p0_size),
        .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_fulfilled(p0_fulfilled), .p0_rdata(p0_rdata),
        .p1_valid(p1_valid), .p1_op(p1_op), .p1_size(p1_size),
        .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_fulfilled(p1_fulfilled), .p1_rdata(p1_rdata),
        .hmem_valid(hmem_valid), .hmem_op(hmem_op), .hmem_size(hmem_size),
        .hmem_addr(hmem_addr), .hmem_wdata(hmem_wdata),
        .hmem_fulfilled(hmem_fulfilled), .hmem_rdata(hmem_rdata),
        .stall_cnt0(stall_cnt0), .stall_cnt1(stall_cnt1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        op;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;
    typedef struct { int cyc; logic v0; logic v1; txn_t t; } req_t;
    typedef struct { int cyc; logic [31:0] rdata; } done_t;
    typedef struct { int cyc; int port; logic [31:0] rdata; } comp_t;

    int     checks = 0;
    int     errors = 0;
    int     cyc    = 0;

    txn_t   pend0[$], pend1[$], sent0[$], sent1[$];
    req_t   req_log[$];
    done_t  done_log[$];
    comp_t  comp_log[$];

    int          gap0, gap1, gap_max;
    int          raise_cyc0, raise_cyc1;
    int          mem_lat, mem_cnt, mem_target, hv_cycles;
    bit          lat_rand, mem_busy, fix_rdata;
    logic [31:0] fix_val;

    function automatic txn_t mk(logic op, logic [1:0] size, logic [31:0] addr,
                                logic [31:0] wdata);
        txn_t t;
        t.op = op; t.size = size; t.addr = addr; t.wdata = wdata;
        return t;
    endfunction

    function automatic txn_t rnd_txn();
        return mk(1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)),
                  $urandom, $urandom);
    endfunction

    // Reference arbitration rule: lone requester wins, a tie goes to the
    // port that was not granted last. -1 means nobody was requesting.
    function automatic int model_pick(logic v0, logic v1, int last);
        if (v0 && v1) return 1 - last;
        if (v0)       return 0;
        if (v1)       return 1;
        return -1;
    endfunction

    // One clock of bench activity, evaluated at the falling edge: the memory
    // responder answers, then each requester retires or raises a request.
    task automatic tick();
        @(negedge clk);
        cyc++;
        hmem_fulfilled = 1'b0;
        if (hmem_valid) begin
            hv_cycles++;
            if (!mem_busy) begin
                req_t r;
                r.cyc = cyc; r.v0 = p0_valid; r.v1 = p1_valid;
                r.t   = mk(hmem_op, hmem_size, hmem_addr, hmem_wdata);
                req_log.push_back(r);
                mem_busy   = 1'b1;
                mem_cnt    = 0;
                mem_target = lat_rand ? $urandom_range(1, 5) : mem_lat;
            end
            mem_cnt++;
            if (mem_cnt >= mem_target) begin
                done_t d;
                hmem_fulfilled = 1'b1;
                hmem_rdata     = fix_rdata ? fix_val : $urandom;
                d.cyc = cyc; d.rdata = hmem_rdata;
                done_log.push_back(d);
                mem_busy = 1'b0;
            end
        end

        if (p0_fulfilled) begin
            comp_t c;
            c.cyc = cyc; c.port = 0; c.rdata = p0_rdata;
            comp_log.push_back(c);
            p0_valid = 1'b0;
            gap0 = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
        end else if (!p0_valid && pend0.size() > 0) begin
            if (gap0 > 0) gap0--;
            else begin
                txn_t t = pend0.pop_front();
                p0_op = t.op; p0_size = t.size; p0_addr = t.addr; p0_wdata = t.wdata;
                p0_valid = 1'b1; sent0.push_back(t); raise_cyc0 = cyc;
            end
        end

        if (p1_fulfilled) begin
            comp_t c;
            c.cyc = cyc; c.port = 1; c.rdata = p1_rdata;
            comp_log.push_back(c);
            p1_valid = 1'b0;
            gap1 = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
        end else if (!p1_valid && pend1.size() > 0) begin
            if (gap1 > 0) gap1--;
            else begin
                txn_t t = pend1.pop_front();
                p1_op = t.op; p1_size = t.size; p1_addr = t.addr; p1_wdata = t.wdata;
                p1_valid = 1'b1; sent1.push_back(t); raise_cyc1 = cyc;
            end
        end
    endtask

    task automatic apply_reset();
        rst_if_i.rst_n = 1'b0;
        p0_valid = 0; p0_op = 0; p0_size = 0; p0_addr = 0; p0_wdata = 0;
        p1_valid = 0; p1_op = 0; p1_size = 0; p1_addr = 0; p1_wdata = 0;
        hmem_fulfilled = 0; hmem_rdata = 0;
        pend0.delete(); pend1.delete(); sent0.delete(); sent1.delete();
        req_log.delete(); done_log.delete(); comp_log.delete();
        gap0 = 0; gap1 = 0; gap_max = 0; mem_lat = 1; mem_busy = 0;
        mem_cnt = 0; hv_cycles = 0; lat_rand = 0; fix_rdata = 0; fix_val = 0;
        raise_cyc0 = 0; raise_cyc1 = 0;
        repeat (2) @(negedge clk);
        rst_if_i.rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (hmem_valid !== 1'b0 || p0_fulfilled !== 1'b0 || p1_fulfilled !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: hmem_valid=%b p0_ful=%b p1_ful=%b, expected 0 0 0",
                     hmem_valid, p0_fulfilled, p1_fulfilled);
        end
        checks++;
        if (hmem_addr !== 32'd0 || hmem_wdata !== 32'd0 || hmem_op !== 1'b0 ||
            hmem_size !== 2'd0 || p0_rdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_fields: addr=%h wdata=%h op=%b size=%0d rdata=%h, expected all 0",
                     hmem_addr, hmem_wdata, hmem_op, hmem_size, p0_rdata);
        end
        checks++;
        if (stall_cnt0 !== 32'd0 || stall_cnt1 !== 32'd0) begin
            errors++;
            $display("FAIL reset_stall: cnt0=%0d cnt1=%0d, expected 0 0", stall_cnt0, stall_cnt1);
        end
    endtask

    task automatic test_single_read();
        apply_reset();
        mem_lat = 3; fix_rdata = 1; fix_val = 32'hDEAD_BEEF;
        pend0.push_back(mk(1'b0, 2'd2, 32'h100, 32'h0));
        for (int i = 0; i < 60 && comp_log.size() < 1; i++) tick();
        repeat (3) tick();
        checks++;
        if (comp_log.size() != 1 || req_log.size() != 1) begin
            errors++;
            $display("FAIL single_count: completions=%0d requests=%0d, expected 1 1",
                     comp_log.size(), req_log.size());
        end else begin
            checks++;
            if (req_log[0].cyc != raise_cyc0 + 1 || req_log[0].t.addr !== 32'h100 ||
                req_log[0].t.op !== 1'b0) begin
                errors++;
                $display("FAIL single_grant: delay=%0d addr=%h op=%b, expected 1 100 0",
                         req_log[0].cyc - raise_cyc0, req_log[0].t.addr, req_log[0].t.op);
            end
            checks++;
            if (hv_cycles != 3) begin
                errors++;
                $display("FAIL single_busy_len: hmem_valid cycles=%0d, expected 3", hv_cycles);
            end
            checks++;
            if (comp_log[0].port != 0 || comp_log[0].rdata !== 32'hDEAD_BEEF ||
                comp_log[0].cyc != done_log[0].cyc + 1) begin
                errors++;
                $display("FAIL single_resp: port=%0d rdata=%h lag=%0d, expected 0 deadbeef 1",
                         comp_log[0].port, comp_log[0].rdata, comp_log[0].cyc - done_log[0].cyc);
            end
        end
    endtask

    task automatic test_tie_fairness();
        apply_reset();
        lat_rand = 1;
        for (int i = 0; i < 3; i++) begin
            pend0.push_back(rnd_txn());
            pend1.push_back(rnd_txn());
        end
        for (int i = 0; i < 400 && comp_log.size() < 6; i++) tick();
        checks++;
        if (comp_log.size() != 6 || req_log.size() != 6) begin
            errors++;
            $display("FAIL fair_count: completions=%0d requests=%0d, expected 6 6",
                     comp_log.size(), req_log.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                txn_t e = (i % 2 == 1) ? sent1[i / 2] : sent0[i / 2];
                checks++;
                if (comp_log[i].port != i % 2 || req_log[i].t !== e) begin
                    errors++;
                    $display("FAIL fair_order[%0d]: port=%0d addr=%h, expected port %0d addr %h",
                             i, comp_log[i].port, req_log[i].t.addr, i % 2, e.addr);
                end
                checks++;
                if ((!e.op && comp_log[i].rdata !== done_log[i].rdata) ||
                    comp_log[i].cyc != done_log[i].cyc + 1) begin
                    errors++;
                    $display("FAIL fair_resp[%0d]: rdata=%h lag=%0d, expected %h 1", i,
                             comp_log[i].rdata, comp_log[i].cyc - done_log[i].cyc,
                             done_log[i].rdata);
                end
                if (i < 5) begin
                    checks++;
                    if (req_log[i + 1].cyc != done_log[i].cyc + 3) begin
                        errors++;
                        $display("FAIL fair_spacing[%0d]: gap=%0d, expected 3", i,
                                 req_log[i + 1].cyc - done_log[i].cyc);
                    end
                end
            end
        end
    endtask

    task automatic test_write_hold();
        int seen = 0;
        apply_reset();
        mem_lat = 4;
        pend1.push_back(mk(1'b1, 2'd0, 32'h203, 32'hAB));
        for (int i = 0; i < 20 && !hmem_valid; i++) tick();
        p1_addr = 32'h0000_0BAD; p1_wdata = 32'h55; p1_op = 1'b0; p1_size = 2'd2;
        for (int i = 0; i < 20 && comp_log.size() < 1; i++) begin
            if (hmem_valid) begin
                seen++;
                checks++;
                if (hmem_addr !== 32'h203 || hmem_op !== 1'b1 || hmem_size !== 2'd0 ||
                    hmem_wdata !== 32'hAB) begin
                    errors++;
                    $display("FAIL hold_fields: addr=%h op=%b size=%0d wdata=%h, expected 203 1 0 ab",
                             hmem_addr, hmem_op, hmem_size, hmem_wdata);
                end
            end
            tick();
        end
        checks++;
        if (seen != 4 || comp_log.size() != 1 || comp_log[0].port != 1) begin
            errors++;
            $display("FAIL hold_done: busy_seen=%0d completions=%0d, expected 4 1 on port 1",
                     seen, comp_log.size());
        end
    endtask

    task automatic test_reset_busy();
        apply_reset();
        mem_lat = 5;
        pend0.push_back(mk(1'b0, 2'd2, 32'h300, 32'h0));
        for (int i = 0; i < 20 && !hmem_valid; i++) tick();
        tick();
        rst_if_i.rst_n = 1'b0;
        #1;
        checks++;
        if (hmem_valid !== 1'b0 || hmem_addr !== 32'd0 || p0_fulfilled !== 1'b0) begin
            errors++;
            $display("FAIL rst_busy_async: hmem_valid=%b addr=%h p0_ful=%b, expected 0 0 0",
                     hmem_valid, hmem_addr, p0_fulfilled);
        end
        apply_reset();
        mem_lat = 2;
        pend1.push_back(mk(1'b0, 2'd1, 32'h40, 32'h0));
        for (int i = 0; i < 30 && comp_log.size() < 1; i++) tick();
        checks++;
        if (comp_log.size() != 1 || req_log.size() != 1) begin
            errors++;
            $display("FAIL rst_busy_after: completions=%0d requests=%0d, expected 1 1",
                     comp_log.size(), req_log.size());
        end else begin
            checks++;
            if (comp_log[0].port != 1 || req_log[0].t.addr !== 32'h40 ||
                req_log[0].cyc != raise_cyc1 + 1 || comp_log[0].rdata !== done_log[0].rdata) begin
                errors++;
                $display("FAIL rst_busy_p1: port=%0d addr=%h delay=%0d rdata=%h, expected 1 40 1 %h",
                         comp_log[0].port, req_log[0].t.addr, req_log[0].cyc - raise_cyc1,
                         comp_log[0].rdata, done_log[0].rdata);
            end
        end
    endtask

    task automatic test_spurious_fulfilled();
        apply_reset();
        tick();
        hmem_fulfilled = 1'b1;
        hmem_rdata     = 32'h1234_5678;
        repeat (3) tick();
        checks++;
        if (comp_log.size() != 0 || hv_cycles != 0) begin
            errors++;
            $display("FAIL spurious_idle: completions=%0d busy_cycles=%0d, expected 0 0",
                     comp_log.size(), hv_cycles);
        end
        mem_lat = 1;
        pend0.push_back(mk(1'b0, 2'd2, 32'h500, 32'h0));
        for (int i = 0; i < 20 && comp_log.size() < 1; i++) tick();
        repeat (2) tick();
        checks++;
        if (comp_log.size() != 1 || hv_cycles != 1) begin
            errors++;
            $display("FAIL spurious_next: completions=%0d busy_cycles=%0d, expected 1 1",
                     comp_log.size(), hv_cycles);
        end
    endtask

    task automatic test_stall_cnt();
        int exp1;
        apply_reset();
        mem_lat = 4;
        pend0.push_back(mk(1'b0, 2'd2, 32'h600, 32'h0));
        pend1.push_back(mk(1'b1, 2'd2, 32'h604, 32'h77));
        for (int i = 0; i < 40 && comp_log.size() < 2; i++) tick();
        repeat (2) tick();
`ifdef MEM_ARB_STALL_CNT_EN
        exp1 = 6;
`else
        exp1 = 0;
`endif
        checks++;
        if (comp_log.size() != 2 || comp_log[0].port != 0 || comp_log[1].port != 1) begin
            errors++;
            $display("FAIL stall_order: completions=%0d, expected ports 0 then 1", comp_log.size());
        end
        checks++;
        if (stall_cnt1 !== 32'(exp1) || stall_cnt0 !== 32'd0) begin
            errors++;
            $display("FAIL stall_counts: cnt0=%0d cnt1=%0d, expected 0 %0d",
                     stall_cnt0, stall_cnt1, exp1);
        end
    endtask

    task automatic test_random();
        int n0, n1, total, last, k0, k1, pick;
        apply_reset();
        lat_rand = 1; gap_max = 3;
        n0 = $urandom_range(4, 8); n1 = $urandom_range(4, 8); total = n0 + n1;
        for (int i = 0; i < n0; i++) pend0.push_back(rnd_txn());
        for (int i = 0; i < n1; i++) pend1.push_back(rnd_txn());
        for (int i = 0; i < 2000 && comp_log.size() < total; i++) tick();
        checks++;
        if (comp_log.size() != total || req_log.size() != total) begin
            errors++;
            $display("FAIL rand_count: completions=%0d requests=%0d, expected %0d",
                     comp_log.size(), req_log.size(), total);
        end else begin
            last = 1; k0 = 0; k1 = 0;
            for (int i = 0; i < total; i++) begin
                txn_t e;
                pick = model_pick(req_log[i].v0, req_log[i].v1, last);
                last = pick;
                if (pick == 1) e = sent1[k1++];
                else           e = sent0[k0++];
                checks++;
                if (comp_log[i].port != pick || req_log[i].t !== e) begin
                    errors++;
                    $display("FAIL rand_grant[%0d]: port=%0d addr=%h, expected port %0d addr %h",
                             i, comp_log[i].port, req_log[i].t.addr, pick, e.addr);
                end
                checks++;
                if ((!e.op && comp_log[i].rdata !== done_log[i].rdata) ||
                    comp_log[i].cyc != done_log[i].cyc + 1) begin
                    errors++;
                    $display("FAIL rand_resp[%0d]: rdata=%h lag=%0d, expected %h 1", i,
                             comp_log[i].rdata, comp_log[i].cyc - done_log[i].cyc,
                             done_log[i].rdata);
                end
            end
        end
    endtask

    initial begin
        rst_if_i.rst_n = 1'b0;
        test_reset();
        test_single_read();
        test_tie_fairness();
        test_write_hold();
        test_reset_busy();
        test_spurious_fulfilled();
        test_stall_cnt();
        for (int r = 0; r < 3; r++) test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d, expected completion", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Two-to-one arbiter merging the lower-level memory request streams of the instruction cache (port 0) and data cache (port 1) into a single request toward main memory. It sits directly downstream of each cache's higher-memory requester port and upstream of the memory model or controller. It uses round-robin fairness and allows one outstanding transaction. The granted request is latched so the memory side sees stable signals regardless of requester behaviour.

## Interface
- XLEN, 32, address and data width in bits
- clk  input  1  system clock, rising edge
- rst_if  reset_if  —  reset bundle; its reset is asynchronous, active-low
- p0_valid / p1_valid  input  1  requester holds request
- p0_op / p1_op  input  1  0 = read, 1 = write
- p0_size / p1_size  input  2  0 = byte, 1 = half, 2 = word; 3 is illegal
- p0_addr / p1_addr  input  XLEN  byte address
- p0_wdata / p1_wdata  input  XLEN  write data
- p0_fulfilled / p1_fulfilled  output  1  one-cycle completion pulse
- p0_rdata / p1_rdata  output  XLEN  read data, valid with fulfilled
- hmem_valid  output  1  request to memory
- hmem_op, hmem_size, hmem_addr, hmem_wdata  output  1/2/XLEN/XLEN  latched request fields
- hmem_fulfilled  input  1  memory completion pulse
- hmem_rdata  input  XLEN  memory read data, valid with hmem_fulfilled
- stall_cnt0 / stall_cnt1  output  32  per-port stall cycle counts (see Configuration)

## Operation
- FSM with three states: IDLE, BUSY, RESP. Reset state is IDLE.
- IDLE:
  - If neither port is valid, stay in IDLE.
  - If exactly one port is valid, grant it.
  - If both are valid, grant the port not named by last_grant.
  - On a grant: latch op/size/addr/wdata, set owner, set last_grant = owner, and go to BUSY.
- BUSY:
  - hmem_valid = 1, driven from the latched fields.
  - On hmem_fulfilled: latch hmem_rdata into rdata_q and go to RESP.
- RESP:
  - Pulse the owner's fulfilled for exactly one cycle, with p*_rdata = rdata_q. The other port's fulfilled stays 0.
  - hmem_valid = 0.
  - Next state is always IDLE.
- Requesters hold valid and all fields stable until they see fulfilled, then deassert valid the following cycle.
  - Once a request is latched, later changes on its port are ignored until RESP.
- rdata for writes is don't-care. p*_rdata may show rdata_q on both ports; only the fulfilled pulse qualifies it.
- The arbiter passes requests through unchanged and performs no address or size checks.

## Timing
- Grant: the cycle after a request arrives at IDLE, hmem_valid = 1.
- End-to-end latency: 1 cycle (grant) + memory latency (hmem_valid high through the hmem_fulfilled cycle) + 1 cycle (RESP).
- Back-to-back: the port not just served is granted in the IDLE cycle after RESP. Minimum spacing between hmem requests is 2 cycles with hmem_valid low.
- Fairness: with both ports continuously valid, grants strictly alternate.
- hmem_fulfilled outside BUSY is ignored.
- Reset (asynchronous, any state):
  - State → IDLE, last_grant = 1 (port 0 wins the first tie).
  - hmem_valid, both fulfilled outputs, latched fields, rdata_q and stall counters are all cleared to 0.
  - An in-flight memory transaction is abandoned; memory shares the same reset.

## Configuration
- MEM_ARB_STALL_CNT_EN defined:
  - stall_cntN increments each cycle that pN_valid = 1 and the port is not the owner in BUSY or RESP, or loses a grant in IDLE.
  - Counters saturate at 0xFFFF_FFFF and clear only on reset.
- Undefined: counter registers are not built and stall_cnt0/1 are tied to 0. The port list is unchanged.

## Test plan
- Port 0 reads 0x100, memory returns 0xDEADBEEF after 3 cycles:
  - hmem_valid rises 1 cycle after p0_valid and hmem_addr = 0x100.
  - p0_fulfilled pulses 1 cycle after hmem_fulfilled with p0_rdata = 0xDEADBEEF.
  - p1_fulfilled stays 0.
- Both ports valid in the same cycle out of reset → port 0 granted first, then port 1. Completion order is p0_fulfilled then p1_fulfilled.
- Both ports valid continuously for 6 transactions → grant order is 0,1,0,1,0,1.
- Port 1 writes size=0, addr 0x203, wdata 0xAB, and port 1 changes its addr mid-BUSY → hmem_addr stays 0x203 and hmem_op = 1 until hmem_fulfilled.
- rst_if reset asserted in BUSY → hmem_valid = 0 immediately (asynchronous). After release, FSM in IDLE and a new p1 request is granted normally.
- MEM_ARB_STALL_CNT_EN defined: port 1 held waiting through a 4-cycle port 0 transaction → stall_cnt1 = 6 (tie-loss + 4 BUSY + RESP) and stall_cnt0 = 0.
